// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_pkg
// Description : Shared types and helpers for the time-shared IIR biquad
//               cascade. Holds the scheduler state encoding, the MAC
//               operation encoding, the coefficient index map within one
//               section, and width helpers for data, coefficient and
//               accumulator words.
// Revision    : 1.0 - initial release
// ============================================================================
package iir_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2
    } iir_state_t;

    // MAC unit operation select
    typedef enum logic [1:0] {
        MAC_HOLD = 2'd0,
        MAC_LOAD = 2'd1,
        MAC_ADD  = 2'd2,
        MAC_SUB  = 2'd3
    } mac_op_t;

    // Coefficient slot within a section; also the MAC step that uses it
    localparam logic [2:0] K_B0 = 3'd0;
    localparam logic [2:0] K_B1 = 3'd1;
    localparam logic [2:0] K_B2 = 3'd2;
    localparam logic [2:0] K_A1 = 3'd3;
    localparam logic [2:0] K_A2 = 3'd4;

    localparam int NUM_TAPS = 5;

    function automatic int data_width(input int nint, input int nfrac);
        return nint + nfrac;
    endfunction

    function automatic int coef_width(input int nint, input int nfrac);
        return nint + nfrac;
    endfunction

    // Three guard bits on the integer side cover the sum of five products.
    function automatic int acc_width(input int ndint, input int ndfrac,
                                     input int ncint, input int ncfrac);
        return (ndint + ncint + 3) + (ndfrac + ncfrac);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iir_mac_dsp48.sv
`default_nettype none
// ============================================================================
// Module      : iir_mac_dsp48
// Description : Signed multiply-accumulate with load / add / subtract / hold
//               control. The product is folded into the accumulator register
//               on the same edge it is selected.
// Ports       : clk, reset (async, active high)
//               clr      - synchronous zero of the accumulator
//               op       - MAC_HOLD / MAC_LOAD / MAC_ADD / MAC_SUB
//               a, b     - signed multiplicands
//               acc      - signed accumulator value
// Revision    : 1.0 - initial release
// ============================================================================
module iir_mac_dsp48
    import iir_pkg::*;
#(
    parameter int A_W   = 25,
    parameter int B_W   = 18,
    parameter int ACC_W = 46
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  mac_op_t                 op,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    localparam int c_prod_w = A_W + B_W;

    logic signed [c_prod_w-1:0] w_a_ext;
    logic signed [c_prod_w-1:0] w_b_ext;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    r_acc;

    // Widen both operands to the full product width so the multiply is
    // evaluated at that width; the exact product always fits.
    assign w_a_ext    = {{B_W{a[A_W-1]}}, a};
    assign w_b_ext    = {{A_W{b[B_W-1]}}, b};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(ACC_W-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else begin
            case (op)
                MAC_LOAD: r_acc <= w_prod_ext;
                MAC_ADD:  r_acc <= r_acc + w_prod_ext;
                MAC_SUB:  r_acc <= r_acc - w_prod_ext;
                default:  r_acc <= r_acc;
            endcase
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/round_n_sat.sv
`default_nettype none
// ============================================================================
// Module      : round_n_sat
// Description : Round-half-up by SHIFT LSBs, then saturate to OUT_W bits.
// Ports       : din  - signed input word (IN_W bits)
//               dout - rounded, clamped signed result (OUT_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module round_n_sat #(
    parameter int IN_W  = 46,
    parameter int OUT_W = 25,
    parameter int SHIFT = 14
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam int c_sum_w = IN_W + 1;
    localparam int c_sh_w  = IN_W + 1 - SHIFT;

    localparam logic signed [c_sum_w-1:0] c_half =
        {{(c_sum_w-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [c_sh_w-1:0] c_max =
        {{(c_sh_w-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [c_sh_w-1:0] c_min =
        {{(c_sh_w-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [c_sum_w-1:0] w_sum;
    logic signed [c_sh_w-1:0]  w_sh;

    // One extra bit keeps the half-LSB addition from wrapping at full scale.
    assign w_sum = {din[IN_W-1], din} + c_half;
    assign w_sh  = c_sh_w'(w_sum >>> SHIFT);

    always_comb begin
        dout = w_sh[OUT_W-1:0];
        if (w_sh > c_max) begin
            dout = c_max[OUT_W-1:0];
        end else if (w_sh < c_min) begin
            dout = c_min[OUT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/iir_cascade_sched.sv
`default_nettype none
// ============================================================================
// Module      : iir_cascade_sched
// Description : Runs Nsec cascaded Direct Form I biquads on one shared MAC.
//               Each section takes five MAC cycles (b0,b1,b2,-a1,-a2) and
//               one write-back cycle; the section output feeds the next
//               section's input.
// Ports       : clk, reset (async, active high)
//               dv_in/d_in        - input sample strobe and value
//               dv_out/d_out      - result pulse and held result
//               busy              - a sample is in flight
//               flush             - clear history, abort in-flight sample
//               coef_we/addr/data - coefficient write, addr = {section, k}
//               ovr, coef_err     - sticky error flags, cleared by err_clr
// Revision    : 1.0 - initial release
// ============================================================================
module iir_cascade_sched
    import iir_pkg::*;
#(
    parameter int Nsec   = 4,
    parameter int Ndint  = 3,
    parameter int Ndfrac = 22,
    parameter int Ncint  = 4,
    parameter int Ncfrac = 14
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dv_in,
    input  logic [Ndint+Ndfrac-1:0]    d_in,
    output logic                       dv_out,
    output logic [Ndint+Ndfrac-1:0]    d_out,
    output logic                       busy,
    input  logic                       flush,
    input  logic                       coef_we,
    input  logic [$clog2(Nsec)+2:0]    coef_addr,
    input  logic [Ncint+Ncfrac-1:0]    coef_data,
    output logic                       ovr,
    output logic                       coef_err,
    input  logic                       err_clr
);

    localparam int c_dw   = data_width(Ndint, Ndfrac);
    localparam int c_cw   = coef_width(Ncint, Ncfrac);
    localparam int c_accw = acc_width(Ndint, Ndfrac, Ncint, Ncfrac);
    localparam int c_aw   = $clog2(Nsec) + 3;
    localparam int c_sw   = (Nsec > 1) ? $clog2(Nsec) : 1;

    iir_state_t r_state;
    iir_state_t w_state_nxt;

    logic [c_sw-1:0]        r_sec;
    logic [2:0]             r_step;
    logic signed [c_dw-1:0] r_xin;
    logic signed [c_dw-1:0] r_x1 [Nsec];
    logic signed [c_dw-1:0] r_x2 [Nsec];
    logic signed [c_dw-1:0] r_y1 [Nsec];
    logic signed [c_dw-1:0] r_y2 [Nsec];
    logic signed [c_cw-1:0] r_coef [Nsec][NUM_TAPS];

    logic                   r_dv_out;
    logic [c_dw-1:0]        r_d_out;
    logic                   r_ovr;
    logic                   r_coef_err;

    logic                   w_accept;
    logic                   w_wb_commit;
    logic                   w_last;
    logic                   w_busy;
    mac_op_t                w_mac_op;
    logic signed [c_dw-1:0] w_mac_a;
    logic signed [c_cw-1:0] w_mac_b;
    logic signed [c_accw-1:0] w_acc;
    logic signed [c_dw-1:0] w_r;
    logic [c_aw-1:0]        w_addr_sec;
    logic                   w_coef_wr;

    assign w_busy = (r_state != ST_IDLE);
    assign w_last = (r_sec == c_sw'(Nsec - 1));

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // flush overrides everything, so accept/commit are never raised with it.
    always_comb begin
        w_state_nxt = r_state;
        w_mac_op    = MAC_HOLD;
        w_accept    = 1'b0;
        w_wb_commit = 1'b0;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dv_in) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_MAC;
                    end
                end
                ST_MAC: begin
                    case (r_step)
                        K_B0:       w_mac_op = MAC_LOAD;
                        K_B1, K_B2: w_mac_op = MAC_ADD;
                        default:    w_mac_op = MAC_SUB;
                    endcase
                    if (r_step == K_A2) begin
                        w_state_nxt = ST_WB;
                    end
                end
                ST_WB: begin
                    w_wb_commit = 1'b1;
                    w_state_nxt = w_last ? ST_IDLE : ST_MAC;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand selection: the step number doubles as the coefficient index
    // ------------------------------------------------------------------
    always_comb begin
        w_mac_a = r_xin;
        w_mac_b = r_coef[r_sec][K_B0];
        case (r_step)
            K_B1: begin
                w_mac_a = r_x1[r_sec];
                w_mac_b = r_coef[r_sec][K_B1];
            end
            K_B2: begin
                w_mac_a = r_x2[r_sec];
                w_mac_b = r_coef[r_sec][K_B2];
            end
            K_A1: begin
                w_mac_a = r_y1[r_sec];
                w_mac_b = r_coef[r_sec][K_A1];
            end
            K_A2: begin
                w_mac_a = r_y2[r_sec];
                w_mac_b = r_coef[r_sec][K_A2];
            end
            default: begin
                w_mac_a = r_xin;
                w_mac_b = r_coef[r_sec][K_B0];
            end
        endcase
    end

    iir_mac_dsp48 #(
        .A_W   (c_dw),
        .B_W   (c_cw),
        .ACC_W (c_accw)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .op    (w_mac_op),
        .a     (w_mac_a),
        .b     (w_mac_b),
        .acc   (w_acc)
    );

    round_n_sat #(
        .IN_W  (c_accw),
        .OUT_W (c_dw),
        .SHIFT (Ncfrac)
    ) u_rns (
        .din  (w_acc),
        .dout (w_r)
    );

    // ------------------------------------------------------------------
    // Section / step counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sec  <= '0;
            r_step <= '0;
        end else if (flush || w_accept) begin
            r_sec  <= '0;
            r_step <= '0;
        end else if (r_state == ST_MAC) begin
            r_step <= (r_step == K_A2) ? 3'd0 : r_step + 3'd1;
        end else if (w_wb_commit && !w_last) begin
            r_sec <= r_sec + c_sw'(1);
        end
    end

    // ------------------------------------------------------------------
    // Section input and x/y history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xin <= '0;
            for (int i = 0; i < Nsec; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else if (flush) begin
            r_xin <= '0;
            for (int i = 0; i < Nsec; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else if (w_accept) begin
            r_xin <= d_in;
        end else if (w_wb_commit) begin
            // This section's result becomes the next section's input.
            r_xin        <= w_r;
            r_x2[r_sec]  <= r_x1[r_sec];
            r_x1[r_sec]  <= r_xin;
            r_y2[r_sec]  <= r_y1[r_sec];
            r_y1[r_sec]  <= w_r;
        end
    end

    // ------------------------------------------------------------------
    // Coefficient register file: writable only between samples, so a
    // sample always sees one consistent coefficient set.
    // ------------------------------------------------------------------
    assign w_addr_sec = coef_addr >> 3;
    assign w_coef_wr  = coef_we && !w_busy
                     && (coef_addr[2:0] < 3'd5)
                     && (w_addr_sec < c_aw'(Nsec));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < Nsec; s++) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    r_coef[s][k] <= '0;
                end
            end
        end else if (w_coef_wr) begin
            r_coef[w_addr_sec[c_sw-1:0]][coef_addr[2:0]] <= coef_data;
        end
    end

    // ------------------------------------------------------------------
    // Result and sticky flags (a new event wins over err_clr)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dv_out   <= 1'b0;
            r_d_out    <= '0;
            r_ovr      <= 1'b0;
            r_coef_err <= 1'b0;
        end else begin
            r_dv_out <= w_wb_commit && w_last;
            if (w_wb_commit && w_last) begin
                r_d_out <= w_r;
            end
            r_ovr      <= (dv_in && w_busy && !flush) || (r_ovr && !err_clr);
            r_coef_err <= (coef_we && w_busy) || (r_coef_err && !err_clr);
        end
    end

    assign dv_out   = r_dv_out;
    assign d_out    = r_d_out;
    assign busy     = w_busy;
    assign ovr      = r_ovr;
    assign coef_err = r_coef_err;

endmodule
`default_nettype wire

// File: tb/tb_iir_cascade_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_cascade_sched
// Description : Directed scoreboard bench for iir_cascade_sched with three
//               sections. Section 0 carries the filter under test; sections
//               1 and 2 are unity pass-through (b0 = 1.0). Expected outputs
//               and their arrival cycles are queued when a sample is issued;
//               a monitor pops and compares on every dv_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_cascade_sched;

    localparam int NSEC = 3;
    localparam int DW   = 25;
    localparam int CW   = 18;
    localparam int AW   = 5;
    localparam int LAT  = 6 * NSEC;

    logic          clk = 1'b0;
    logic          reset;
    logic          dv_in;
    logic [DW-1:0] d_in;
    logic          dv_out;
    logic [DW-1:0] d_out;
    logic          busy;
    logic          flush;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          ovr;
    logic          coef_err;
    logic          err_clr;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [DW-1:0] mon_e;
    int            mon_c;

    iir_cascade_sched #(
        .Nsec   (NSEC),
        .Ndint  (3),
        .Ndfrac (22),
        .Ncint  (4),
        .Ncfrac (14)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dv_in     (dv_in),
        .d_in      (d_in),
        .dv_out    (dv_out),
        .d_out     (d_out),
        .busy      (busy),
        .flush     (flush),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .ovr       (ovr),
        .coef_err  (coef_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every dv_out must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && dv_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dv_out", {31'd0, dv_out}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("d_out", {7'd0, d_out}, {7'd0, mon_e});
                check("latency", cyc, mon_c);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wcoef(input int sec, input int k, input logic [CW-1:0] val);
        coef_we   = 1'b1;
        coef_addr = AW'(sec * 8 + k);
        coef_data = val;
        tick(1);
        coef_we   = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] e);
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 1 + LAT);
        dv_in = 1'b1;
        d_in  = x;
        tick(1);
        dv_in = 1'b0;
    endtask

    task automatic send_drop(input logic [DW-1:0] x);
        dv_in = 1'b1;
        d_in  = x;
        tick(1);
        dv_in = 1'b0;
    endtask

    // Returns on the dv_out cycle, so the next send is back-to-back.
    task automatic run(input logic [DW-1:0] x, input logic [DW-1:0] e);
        send(x, e);
        tick(LAT);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            tick(1);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; dv_in = 1'b0; d_in = '0; flush = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; err_clr = 1'b0;
        tick(3);
        check("reset_dv_out",   {31'd0, dv_out},   32'd0);
        check("reset_d_out",    {7'd0, d_out},     32'd0);
        check("reset_busy",     {31'd0, busy},     32'd0);
        check("reset_ovr",      {31'd0, ovr},      32'd0);
        check("reset_coef_err", {31'd0, coef_err}, 32'd0);
        reset = 1'b0;
        tick(1);

        // Unity pass-through on all sections, back-to-back samples
        for (int s = 0; s < NSEC; s++) wcoef(s, 0, 18'd16384);
        run(25'h0200000, 25'h0200000);
        run(25'h0123456, 25'h0123456);
        run(25'h1F00000, 25'h1F00000);
        run(25'h0000001, 25'h0000001);
        check("b2b_no_ovr", {31'd0, ovr}, 32'd0);

        // First-order recursion: a1 = -0.5
        do_flush();
        wcoef(0, 3, 18'h3E000);
        run(25'h0400000, 25'h0400000);
        run(25'h0000000, 25'h0200000);
        run(25'h0000000, 25'h0100000);
        run(25'h0000000, 25'h0080000);

        // b1 = 0.5, b2 = 0.25, a2 = -0.25
        do_flush();
        wcoef(0, 3, 18'd0);
        wcoef(0, 1, 18'd8192);
        wcoef(0, 2, 18'd4096);
        wcoef(0, 4, 18'h3F000);
        run(25'h0400000, 25'h0400000);
        run(25'h0000000, 25'h0200000);
        run(25'h0000000, 25'h0200000);
        run(25'h0000000, 25'h0080000);
        run(25'h0000000, 25'h0080000);

        // Saturation with b0 = 0x1FFFF (~8.0)
        do_flush();
        wcoef(0, 1, 18'd0);
        wcoef(0, 2, 18'd0);
        wcoef(0, 4, 18'd0);
        wcoef(0, 0, 18'h1FFFF);
        run(25'h03FFFFF, 25'h0FFFFFF);
        run(25'h1000000, 25'h1000000);

        // Rounding with b0 = 1 LSB: x/16384 rounded half up
        wcoef(0, 0, 18'd1);
        run(25'd8192,     25'd1);
        run(25'h1FFE000,  25'd0);
        run(25'd8191,     25'd0);
        run(25'd24576,    25'd2);
        run(25'h1FFA000,  25'h1FFFFFF);

        // Writes to k=5 and to a nonexistent section are ignored
        wcoef(0, 0, 18'd16384);
        wcoef(0, 5, 18'h2AAAA);
        wcoef(3, 0, 18'h2AAAA);
        run(25'h0000777, 25'h0000777);
        check("ignored_wr_no_err", {31'd0, coef_err}, 32'd0);

        // Overrun, coefficient write while busy, set-wins over err_clr
        send(25'h0000100, 25'h0000100);
        tick(2);
        send_drop(25'h0000999);
        check("ovr_set", {31'd0, ovr}, 32'd1);
        check("busy_mid", {31'd0, busy}, 32'd1);
        wcoef(0, 0, 18'd32768);
        check("coef_err_set", {31'd0, coef_err}, 32'd1);
        err_clr = 1'b1; dv_in = 1'b1; d_in = 25'h0000555;
        tick(1);
        err_clr = 1'b0; dv_in = 1'b0;
        check("ovr_set_wins", {31'd0, ovr}, 32'd1);
        check("coef_err_cleared", {31'd0, coef_err}, 32'd0);
        wait_idle(40);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("ovr_cleared", {31'd0, ovr}, 32'd0);
        run(25'h0000100, 25'h0000100);

        // Coefficient write and sample in the same cycle: new b0 = 0.5 used
        coef_we = 1'b1; coef_addr = AW'(0); coef_data = 18'd8192;
        send(25'h0200000, 25'h0100000);
        coef_we = 1'b0;
        tick(LAT);

        // flush with dv_in: sample dropped, no overrun
        flush = 1'b1; dv_in = 1'b1; d_in = 25'h0000555;
        tick(1);
        flush = 1'b0; dv_in = 1'b0;
        check("flush_drop_busy", {31'd0, busy}, 32'd0);
        check("flush_drop_ovr",  {31'd0, ovr},  32'd0);

        // Build history, abort a sample mid-MAC, then check zero-history response
        wcoef(0, 0, 18'd16384);
        wcoef(0, 3, 18'h3E000);
        run(25'h0400000, 25'h0400000);
        send_drop(25'h0400000);
        tick(2);
        check("busy_before_flush", {31'd0, busy}, 32'd1);
        do_flush();
        check("busy_after_flush", {31'd0, busy}, 32'd0);
        tick(LAT + 2);
        run(25'h0400000, 25'h0400000);
        run(25'h0000000, 25'h0200000);

        // Asynchronous reset mid-sample
        send_drop(25'h0400000);
        tick(3);
        #2 reset = 1'b1;
        #1;
        check("areset_dv_out", {31'd0, dv_out}, 32'd0);
        check("areset_d_out",  {7'd0, d_out},   32'd0);
        check("areset_busy",   {31'd0, busy},   32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        run(25'h03ABCDE, 25'h0000000);
        tick(5);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
